// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
// Readout scheduler for the two-channel comparator ADC. Decides when a CIC
// sample set is captured, snapshots A, B and A-B, and sends the enabled
// channels as one framed packet on a single serial pin:
//   HEADER (4 bits) | per channel: id (2 bits) + data (WIDTH bits) | gap (1 bit)
// Frames start from a strobe divider (auto mode) or from a synchronised
// external trigger edge (external mode). Lost requests raise a sticky overrun.
module adc_frame_scheduler #(
    parameter int          WIDTH    = 13,
    parameter int          AUTO_DIV = 64,
    parameter logic [3:0]  HEADER   = 4'b1010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             auto_mode,
    input  logic             trig_in,
    input  logic [2:0]       ch_mask,
    input  logic             clr_ovr,
    input  logic             sample_strobe,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             serial_out,
    output logic             frame_sync,
    output logic             busy,
    output logic [1:0]       ch_id,
    output logic             overrun
);

    localparam int CW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 2);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(AUTO_DIV - 1);
    localparam logic [BW-1:0] FIELD_LAST = BW'(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Index of the lowest set mask bit at or above 'from'; 3 means none left.
    function automatic logic [1:0] next_ch(input logic [2:0] m, input logic [2:0] from);
        logic [1:0] r;
        r = 2'd3;
        for (int k = 2; k >= 0; k--) begin
            if (m[k] && (k >= int'(from))) r = 2'(k);
        end
        return r;
    endfunction

    logic             trig_s1, trig_s2, trig_d, trig_edge;
    logic [CW-1:0]    strobe_cnt;
    logic             pending;
    logic [1:0]       state;
    logic [1:0]       hdr_cnt;
    logic [1:0]       cur_ch;
    logic [BW-1:0]    bit_cnt;
    logic [2:0]       mask_q;
    logic [WIDTH-1:0] shadow_a, shadow_b, shadow_d;

    logic             idle, auto_tick, ext_tick, start, ovr_event;
    logic [1:0]       nxt_ch;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] field_word;

    assign idle      = (state == S_IDLE);
    assign auto_tick = enable & auto_mode & sample_strobe & (strobe_cnt == DIV_LAST);
    // An external request waits in 'pending' until a strobe finds the scheduler idle.
    assign ext_tick  = enable & ~auto_mode & pending & sample_strobe & idle;
    assign start     = (auto_tick | ext_tick) & idle & (ch_mask != 3'b000);
    assign ovr_event = (auto_tick & ~idle) | (enable & ~auto_mode & trig_edge & pending);
    assign nxt_ch    = next_ch(mask_q, {1'b0, cur_ch} + 3'd1);
    assign bit_idx   = IW'(WIDTH + 1 - int'(bit_cnt));

    // Two-flop synchroniser for trig_in plus registered rising-edge detect.
    // NOTE: flops use non-blocking assignments so each stage samples the previous stage's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_d    <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            trig_s1   <= trig_in;
            trig_s2   <= trig_s1;
            trig_d    <= trig_s2;
            trig_edge <= trig_s2 & ~trig_d;
        end
    end

    // Auto-mode strobe divider; held at zero whenever it is not in use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_cnt <= '0;
        end else if (!(enable && auto_mode)) begin
            strobe_cnt <= '0;
        end else if (sample_strobe) begin
            strobe_cnt <= (strobe_cnt == DIV_LAST) ? '0 : strobe_cnt + CW'(1);
        end
    end

    // External request latch: set by a trigger edge, consumed by a start tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (!(enable && !auto_mode)) begin
            pending <= 1'b0;
        end else if (ext_tick) begin
            pending <= 1'b0;
        end else if (trig_edge) begin
            pending <= 1'b1;
        end
    end

    // Sticky overrun flag; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_event) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    // Sample snapshot at frame start; data inputs are ignored for the rest of the frame.
    // NOTE: shadows carry no reset: they are always written at frame start before any bit of them is sent.
    always_ff @(posedge clk) begin
        if (start) begin
            shadow_a <= data_a;
            shadow_b <= data_b;
            shadow_d <= data_a - data_b;
        end
    end

    // Frame sequencer: IDLE -> HDR -> SEND (one field per enabled channel) -> GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            hdr_cnt <= 2'd0;
            cur_ch  <= 2'd0;
            bit_cnt <= '0;
            mask_q  <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_HDR;
                        hdr_cnt <= 2'd0;
                        bit_cnt <= '0;
                        mask_q  <= ch_mask;
                        cur_ch  <= next_ch(ch_mask, 3'd0);
                    end
                end
                S_HDR: begin
                    if (hdr_cnt == 2'd3) begin
                        state   <= S_SEND;
                        bit_cnt <= '0;
                    end else begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                    end
                end
                S_SEND: begin
                    if (bit_cnt == FIELD_LAST) begin
                        bit_cnt <= '0;
                        if (nxt_ch == 2'd3) begin
                            state <= S_GAP;
                        end else begin
                            cur_ch <= nxt_ch;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode straight from sequencer state, so async reset clears outputs at once.
    // NOTE: every output gets a default first so no path through the block leaves one unassigned (no latches).
    always_comb begin
        serial_out = 1'b0;
        frame_sync = 1'b0;
        ch_id      = 2'd0;
        busy       = (state != S_IDLE);
        case (cur_ch)
            2'd0:    field_word = shadow_a;
            2'd1:    field_word = shadow_b;
            default: field_word = shadow_d;
        endcase
        case (state)
            S_HDR: begin
                serial_out = HEADER[~hdr_cnt];
                frame_sync = (hdr_cnt == 2'd0);
            end
            S_SEND: begin
                ch_id = cur_ch;
                if (bit_cnt < BW'(2)) begin
                    serial_out = cur_ch[~bit_cnt[0]];
                end else begin
                    serial_out = field_word[bit_idx];
                end
            end
            default: begin
                serial_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler
// Two scheduler instances (AUTO_DIV = 4 and AUTO_DIV = 1) share all inputs.
// A frame-level reference model predicts every output of both instances on
// every cycle; table vectors and hand-written sequences add targeted checks.
module tb_adc_frame_scheduler;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         auto_mode = 1'b0;
    logic         trig_in = 1'b0;
    logic [2:0]   ch_mask = 3'b000;
    logic         clr_ovr = 1'b0;
    logic         sample_strobe = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;

    logic       so0, fs0, bz0, ov0;
    logic [1:0] id0;
    logic       so1, fs1, bz1, ov1;
    logic [1:0] id1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adc_frame_scheduler #(.WIDTH(W), .AUTO_DIV(4), .HEADER(4'b1010)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode),
        .trig_in(trig_in), .ch_mask(ch_mask), .clr_ovr(clr_ovr),
        .sample_strobe(sample_strobe), .data_a(data_a), .data_b(data_b),
        .serial_out(so0), .frame_sync(fs0), .busy(bz0), .ch_id(id0), .overrun(ov0)
    );

    adc_frame_scheduler #(.WIDTH(W), .AUTO_DIV(1), .HEADER(4'b1010)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode),
        .trig_in(trig_in), .ch_mask(ch_mask), .clr_ovr(clr_ovr),
        .sample_strobe(sample_strobe), .data_a(data_a), .data_b(data_b),
        .serial_out(so1), .frame_sync(fs1), .busy(bz1), .ch_id(id1), .overrun(ov1)
    );

    // ---------------- reference model ----------------
    // Each instance holds the list of output cycles of its current frame
    // (empty = idle), plus strobe count, pending request and overrun flag.
    logic       m_ser [2][64];
    logic [1:0] m_id  [2][64];
    int         m_pos [2];
    int         m_len [2];
    int         m_cnt [2];
    int         m_div [2];
    logic       m_pend[2];
    logic       m_ovr [2];
    logic [3:0] tq;   // trig_in samples at the last four clock edges, [0] newest

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]  = 0;
            m_len[i]  = 0;
            m_cnt[i]  = 0;
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
        end
        m_div[0] = 4;
        m_div[1] = 1;
        tq = 4'b0000;
    endtask

    task automatic build_frame(input int i, input logic [2:0] m, input logic [W-1:0] a,
                               input logic [W-1:0] b);
        logic [3:0]   hdr;
        logic [W-1:0] w;
        logic [1:0]   c;
        int           len;
        hdr = 4'b1010;
        len = 0;
        for (int k = 3; k >= 0; k--) begin
            m_ser[i][len] = hdr[k];
            m_id[i][len]  = 2'd0;
            len++;
        end
        for (int ch = 0; ch < 3; ch++) begin
            if (m[ch]) begin
                c = 2'(ch);
                w = (ch == 0) ? a : (ch == 1) ? b : W'(a - b);
                m_ser[i][len] = c[1]; m_id[i][len] = c; len++;
                m_ser[i][len] = c[0]; m_id[i][len] = c; len++;
                for (int k = W - 1; k >= 0; k--) begin
                    m_ser[i][len] = w[k];
                    m_id[i][len]  = c;
                    len++;
                end
            end
        end
        m_ser[i][len] = 1'b0;
        m_id[i][len]  = 2'd0;
        len++;
        m_len[i] = len;
        m_pos[i] = 0;
    endtask

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic model_step();
        logic edge_now;
        edge_now = tq[2] & ~tq[3];
        for (int i = 0; i < 2; i++) begin
            logic idle, at, et, ev, st;
            idle = (m_pos[i] >= m_len[i]);
            at = enable && auto_mode && sample_strobe && (m_cnt[i] == m_div[i] - 1);
            et = enable && !auto_mode && m_pend[i] && sample_strobe && idle;
            ev = (at && !idle) || (enable && !auto_mode && edge_now && m_pend[i]);
            st = (at || et) && idle && (ch_mask != 3'b000);
            if (!(enable && auto_mode)) m_cnt[i] = 0;
            else if (sample_strobe)     m_cnt[i] = (m_cnt[i] == m_div[i] - 1) ? 0 : m_cnt[i] + 1;
            if (!(enable && !auto_mode)) m_pend[i] = 1'b0;
            else if (et)                 m_pend[i] = 1'b0;
            else if (edge_now)           m_pend[i] = 1'b1;
            if (ev)           m_ovr[i] = 1'b1;
            else if (clr_ovr) m_ovr[i] = 1'b0;
            if (!idle) m_pos[i]++;
            if (st) build_frame(i, ch_mask, data_a, data_b);
        end
        tq = {tq[2:0], trig_in};
    endtask

    // One clock: update model, let the DUT clock, compare all outputs 1 ns later.
    task automatic step();
        logic [5:0] e, g;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_pos[i] < m_len[i])
                e = {m_ser[i][m_pos[i]], (m_pos[i] == 0), 1'b1, m_id[i][m_pos[i]], m_ovr[i]};
            else
                e = {3'b000, 2'd0, m_ovr[i]};
            g = (i == 0) ? {so0, fs0, bz0, id0, ov0} : {so1, fs1, bz1, id1, ov1};
            check($sformatf("cycle_dut%0d", i), 64'(g), 64'(e));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        trig_in = 1'b0;
        sample_strobe = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]   mask;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           len;
        logic [63:0]  bits;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int nsync, last, first, busy_tot, scnt, bcnt;
        logic [63:0] got;

        tbl[0] = '{3'b111, 13'h1234, 13'h0235, 50,
                   64'b1010_00_1001000110100_01_0001000110101_10_0111111111111_0};
        tbl[1] = '{3'b100, 13'h0000, 13'h0001, 20, 64'b1010_10_1111111111111_0};
        tbl[2] = '{3'b010, 13'h0AAA, 13'h1555, 20, 64'b1010_01_1010101010101_0};
        tbl[3] = '{3'b001, 13'h1FFF, 13'h0000, 20, 64'b1010_00_1111111111111_0};
        tbl[4] = '{3'b101, 13'h0003, 13'h0005, 35,
                   64'b1010_00_0000000000011_10_1111111111110_0};
        tbl[5] = '{3'b000, 13'h0001, 13'h0002, 0, 64'd0};

        model_reset();
        do_reset();
        check("reset_dut0", 64'({so0, fs0, bz0, id0, ov0}), 64'd0);
        check("reset_dut1", 64'({so1, fs1, bz1, id1, ov1}), 64'd0);

        // Table: externally triggered single frames, data_a disturbed mid-frame.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            enable = 1'b1;
            auto_mode = 1'b0;
            ch_mask = tbl[v].mask;
            data_a = tbl[v].a;
            data_b = tbl[v].b;
            trig_in = 1'b1;
            repeat (5) step();
            trig_in = 1'b0;
            got = '0; scnt = 0; bcnt = 0;
            for (int k = 0; k < tbl[v].len + 4; k++) begin
                sample_strobe = (k == 0);
                if (k == 5) data_a = ~data_a;
                step();
                if (k < tbl[v].len) got = {got[62:0], so0};
                scnt += int'(fs0);
                bcnt += int'(bz0);
            end
            sample_strobe = 1'b0;
            check($sformatf("tbl%0d_bits", v), got, tbl[v].bits);
            check($sformatf("tbl%0d_busy", v), 64'(bcnt), 64'(tbl[v].len));
            check($sformatf("tbl%0d_sync", v), 64'(scnt), (tbl[v].len != 0) ? 64'd1 : 64'd0);
            check($sformatf("tbl%0d_ovr", v), 64'(ov0), 64'd0);
        end

        // Auto mode, divide by 4, strobe every 8 clocks, channel B only.
        do_reset();
        enable = 1'b1; auto_mode = 1'b1; ch_mask = 3'b010;
        nsync = 0; last = -1; busy_tot = 0;
        for (int c = 0; c < 186; c++) begin
            sample_strobe = (c % 8 == 7);
            data_a = W'($urandom); data_b = W'($urandom);
            step();
            busy_tot += int'(bz0);
            if (fs0) begin
                if (last >= 0) check("auto_period", 64'(c - last), 64'd32);
                last = c;
                nsync++;
            end
        end
        sample_strobe = 1'b0;
        check("auto_nframes", 64'(nsync), 64'd5);
        check("auto_busy", 64'(busy_tot), 64'd100);
        check("auto_no_ovr", 64'(ov0), 64'd0);

        // Auto mode, divide by 1, long frames: collisions, clear, set-wins.
        do_reset();
        enable = 1'b1; auto_mode = 1'b1; ch_mask = 3'b111;
        for (int c = 0; c < 120; c++) begin
            sample_strobe = (c % 8 == 7);
            clr_ovr = (c == 18) || (c == 31);
            step();
            if (c == 15) check("ovr_set", 64'(ov1), 64'd1);
            if (c == 18) check("ovr_clear", 64'(ov1), 64'd0);
            if (c == 23) check("ovr_reset", 64'(ov1), 64'd1);
            if (c == 31) check("ovr_set_wins", 64'(ov1), 64'd1);
        end
        sample_strobe = 1'b0; clr_ovr = 1'b0;

        // External mode: one edge queued while busy, a second one overruns.
        do_reset();
        enable = 1'b1; auto_mode = 1'b0; ch_mask = 3'b111;
        nsync = 0; last = -1;
        for (int c = 0; c < 130; c++) begin
            trig_in = (c < 4) || (c >= 12 && c < 16) || (c >= 20 && c < 24);
            sample_strobe = (c % 8 == 7);
            step();
            if (fs0) begin nsync++; last = c; end
        end
        trig_in = 1'b0; sample_strobe = 1'b0;
        check("ext_nframes", 64'(nsync), 64'd2);
        check("ext_queued_start", 64'(last), 64'd63);
        check("ext_ovr", 64'(ov0), 64'd1);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        enable = 1'b1; auto_mode = 1'b0; ch_mask = 3'b111;
        for (int c = 0; c < 28; c++) begin
            trig_in = (c < 4);
            sample_strobe = (c % 8 == 7);
            step();
        end
        trig_in = 1'b0; sample_strobe = 1'b0;
        check("pre_rst_busy", 64'(bz0), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dut0", 64'({so0, fs0, bz0, id0, ov0}), 64'd0);
        check("async_rst_dut1", 64'({so1, fs1, bz1, id1, ov1}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // enable dropped mid-frame: frame completes, nothing else starts.
        do_reset();
        enable = 1'b1; auto_mode = 1'b0; ch_mask = 3'b111;
        nsync = 0; busy_tot = 0;
        for (int c = 0; c < 160; c++) begin
            trig_in = (c % 16 < 4);
            sample_strobe = (c % 8 == 7);
            enable = (c < 20);
            step();
            nsync += int'(fs0);
            busy_tot += int'(bz0);
        end
        trig_in = 1'b0; sample_strobe = 1'b0;
        check("dis_nframes", 64'(nsync), 64'd1);
        check("dis_busy", 64'(busy_tot), 64'd50);

        // Re-enable in auto mode restarts the strobe divider from zero.
        do_reset();
        enable = 1'b1; auto_mode = 1'b1; ch_mask = 3'b001;
        first = -1;
        for (int c = 0; c < 100; c++) begin
            sample_strobe = (c % 8 == 7);
            enable = !(c >= 26 && c < 28);
            step();
            if (fs0 && first < 0) first = c;
        end
        sample_strobe = 1'b0; enable = 1'b1;
        check("reenable_first_frame", 64'(first), 64'd55);

        // Randomised traffic in both modes against the model.
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            auto_mode = mode[0];
            for (int c = 0; c < 3000; c++) begin
                sample_strobe = ($urandom_range(0, 5) == 0);
                data_a = W'($urandom);
                data_b = W'($urandom);
                ch_mask = 3'($urandom);
                clr_ovr = ($urandom_range(0, 40) == 0);
                enable = ($urandom_range(0, 60) != 0);
                if ($urandom_range(0, 9) == 0) trig_in = ~trig_in;
                step();
            end
            sample_strobe = 1'b0; clr_ovr = 1'b0; trig_in = 1'b0; enable = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
